// File: rtl/vga_sync_decoder_if.sv
// Sync bus between a VGA sync generator (master) and the sync decoder (slave):
// the active-low sync pulses plus everything recovered from them.
interface vga_sync_decoder_if;
    logic       vga_HS;
    logic       vga_VS;
    logic [9:0] pos_H;
    logic [9:0] pos_V;
    logic       vga_Ready;
    logic       locked;
    logic       frame_start;
    logic [7:0] err_cnt;

    modport master (
        output vga_HS, vga_VS,
        input  pos_H, pos_V, vga_Ready, locked, frame_start, err_cnt
    );

    modport slave (
        input  vga_HS, vga_VS,
        output pos_H, pos_V, vga_Ready, locked, frame_start, err_cnt
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position / active-video from VGA HS/VS and checks line/frame timing.
// Optional sync pulse-width checks are enabled by defining VGA_PULSE_CHECK_EN.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_FRONT     = 16,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 32,
    parameter int V_FRONT     = 11,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                vga_CLK,
    input  logic                vga_RST_n,
    vga_sync_decoder_if.slave   bus
);

    localparam logic [9:0] POS_MAX  = 10'h3FF;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_TOTAL - 1 - H_FRONT);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_TOTAL - 1 - V_FRONT);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == POS_MAX) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       hs_q, vs_q;
    logic [9:0] pos_h_q, pos_v_q;
    logic       locked_q, frame_start_q;
    logic [7:0] err_q, err_d;
    logic [3:0] good_q, good_d, good_inc;
    state_t     state_q, state_d;

    logic hs_fall, vs_fall, aligned;
    logic line_err, frame_err, align_err, tmo, pulse_err, bad;

    // Edge detection and timing checks against the pre-update counters
    assign hs_fall   = hs_q & ~bus.vga_HS;
    assign vs_fall   = vs_q & ~bus.vga_VS;
    assign aligned   = hs_fall & vs_fall;

    assign line_err  = hs_fall & (pos_h_q != H_LAST);
    assign frame_err = vs_fall & (pos_v_q != V_LAST);
    assign align_err = vs_fall & ~hs_fall;
    assign tmo       = ((pos_h_q == POS_MAX) & ~hs_fall) | (pos_v_q == POS_MAX);

`ifdef VGA_PULSE_CHECK_EN
    localparam logic [9:0] H_PULSE_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] V_PULSE_LAST = 10'(V_SYNC - 1);
    logic hs_rise, vs_rise;
    assign hs_rise   = ~hs_q & bus.vga_HS;
    assign vs_rise   = ~vs_q & bus.vga_VS;
    assign pulse_err = (hs_rise & (pos_h_q != H_PULSE_LAST))
                     | (vs_rise & ((pos_v_q != V_PULSE_LAST) | ~hs_fall));
`else
    assign pulse_err = 1'b0;
`endif

    assign bad = line_err | frame_err | align_err | tmo | pulse_err;

    // Position counters and sync sample registers
    always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
        if (!vga_RST_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            pos_h_q       <= '0;
            pos_v_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hs_q          <= bus.vga_HS;
            vs_q          <= bus.vga_VS;
            pos_h_q       <= hs_fall ? '0 : sat_inc10(pos_h_q);
            if (aligned)
                pos_v_q <= '0;
            else if (hs_fall)
                pos_v_q <= sat_inc10(pos_v_q);
            frame_start_q <= aligned;
        end
    end

    // Lock FSM: state register
    always_ff @(posedge vga_CLK or negedge vga_RST_n) begin
        if (!vga_RST_n) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    assign good_inc = good_q + 4'd1;

    // Timing errors are meaningless until an aligned vsync has been seen, so SEARCH ignores bad.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        unique case (state_q)
            SEARCH: begin
                if (aligned) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (bad) begin
                    state_d = SEARCH;
                end else if (aligned) begin
                    good_d = good_inc;
                    if (good_inc == LOCK_N)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_d = SEARCH;
                    err_d   = sat_inc8(err_q);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign bus.pos_H       = pos_h_q;
    assign bus.pos_V       = pos_v_q;
    assign bus.locked      = locked_q;
    assign bus.frame_start = frame_start_q;
    assign bus.err_cnt     = err_q;
    assign bus.vga_Ready   = locked_q
                           & (pos_h_q >= H_ACT_LO) & (pos_h_q <= H_ACT_HI)
                           & (pos_v_q >= V_ACT_LO) & (pos_v_q <= V_ACT_HI);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: generator-driven stream, with line stretch, HS stall,
// mid-frame reset and short HS pulse, checked every cycle against a reference model.
module tb_vga_sync_decoder;
    localparam int H_SYNC = 8, H_BACK = 4, H_FRONT = 4, H_TOTAL = 40;
    localparam int V_SYNC = 2, V_BACK = 3, V_FRONT = 2, V_TOTAL = 15;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int ACT_PIX = (H_TOTAL - H_SYNC - H_BACK - H_FRONT)
                           * (V_TOTAL - V_SYNC - V_BACK - V_FRONT);

    logic vga_CLK = 1'b0;
    logic vga_RST_n = 1'b1;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .vga_CLK  (vga_CLK),
        .vga_RST_n(vga_RST_n),
        .bus      (bus)
    );

    always #5 vga_CLK = ~vga_CLK;

    int passed = 0;
    int total  = 0;

    // Reference model: time since the last HS fall, lines since the last aligned
    // vsync, and the number of aligned vsyncs seen since timing last went bad.
    int   edge_n, h_origin, v_lines, clean, m_err;
    logic m_fs, prev_hs, prev_vs, last_hsf, last_aligned;
    // Generator state
    int   gh, gv, hs_w, drove_h, drove_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_ph();
        return (edge_n - h_origin > 1023) ? 1023 : edge_n - h_origin;
    endfunction

    function automatic bit m_locked();
        return clean >= LOCK_FRAMES + 1;
    endfunction

    function automatic bit m_ready();
        int ph;
        ph = m_ph();
        return m_locked() && ph >= H_SYNC + H_BACK && ph <= H_TOTAL - 1 - H_FRONT
            && v_lines >= V_SYNC + V_BACK && v_lines <= V_TOTAL - 1 - V_FRONT;
    endfunction

    task automatic model_reset();
        edge_n = 0; h_origin = 0; v_lines = 0; clean = 0; m_err = 0;
        m_fs = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; last_hsf = 1'b0; last_aligned = 1'b0;
    endtask

    task automatic check_outputs();
        check("pos_H", 32'(bus.pos_H), m_ph());
        check("pos_V", 32'(bus.pos_V), v_lines);
        check("vga_Ready", 32'(bus.vga_Ready), 32'(m_ready()));
        check("locked", 32'(bus.locked), 32'(m_locked()));
        check("frame_start", 32'(bus.frame_start), 32'(m_fs));
        check("err_cnt", 32'(bus.err_cnt), m_err);
    endtask

    task automatic tick(input logic hs, input logic vs);
        int ph, pv;
        bit hsf, vsf, bad;
        bus.vga_HS = hs;
        bus.vga_VS = vs;
        @(posedge vga_CLK);
        ph  = m_ph();
        pv  = v_lines;
        hsf = prev_hs && !hs;
        vsf = prev_vs && !vs;
        bad = (hsf && ph != H_TOTAL - 1) || (vsf && pv != V_TOTAL - 1) || (vsf && !hsf)
           || (ph == 1023 && !hsf) || (pv == 1023);
`ifdef VGA_PULSE_CHECK_EN
        if (!prev_hs && hs && ph != H_SYNC - 1) bad = 1'b1;
        if (!prev_vs && vs && (pv != V_SYNC - 1 || !hsf)) bad = 1'b1;
`endif
        if (clean > 0 && bad) begin
            if (m_locked() && m_err < 255) m_err++;
            clean = 0;
        end else if (hsf && vsf && clean < 1000) begin
            clean++;
        end
        m_fs = hsf && vsf;
        edge_n++;
        if (hsf) h_origin = edge_n;
        if (hsf && vsf) v_lines = 0;
        else if (hsf && v_lines < 1023) v_lines++;
        prev_hs = hs; prev_vs = vs;
        last_hsf = hsf; last_aligned = hsf && vsf;
        #1;
        check_outputs();
    endtask

    task automatic gen_tick(input bit hold);
        drove_h = gh;
        drove_v = gv;
        tick(gh >= hs_w, gv >= V_SYNC);
        if (!hold) begin
            gh++;
            if (gh == H_TOTAL) begin
                gh = 0;
                gv = (gv + 1) % V_TOTAL;
            end
        end
    endtask

    task automatic run_vsyncs(input int n);
        int seen, cyc;
        seen = 0; cyc = 0;
        while (seen < n && cyc < (n + 2) * FRAME) begin
            gen_tick(1'b0);
            cyc++;
            if (last_aligned) seen++;
        end
        check("vsync_wait", seen, n);
    endtask

    task automatic goto_gen(input int h, input int v);
        int cyc;
        cyc = 0;
        while (!(gh == h && gv == v) && cyc < 2 * FRAME) begin
            gen_tick(1'b0);
            cyc++;
        end
        check("gen_position", cyc < 2 * FRAME, 1);
    endtask

    initial begin
        int cyc, rdy, fh, fv, lag_bad, unlock_ph;
        bus.vga_HS = 1'b1;
        bus.vga_VS = 1'b1;
        gh = $urandom_range(0, H_TOTAL - 1);
        gv = $urandom_range(0, V_TOTAL - 1);
        hs_w = H_SYNC;
        model_reset();

        // Reset: outputs clear asynchronously, before any clock edge
        #1 vga_RST_n = 1'b0;
        #1;
        check("rst_pos_H", 32'(bus.pos_H), 0);
        check("rst_pos_V", 32'(bus.pos_V), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_ready", 32'(bus.vga_Ready), 0);
        check("rst_fs", 32'(bus.frame_start), 0);
        check("rst_err", 32'(bus.err_cnt), 0);
        repeat (2) @(posedge vga_CLK);
        #1 vga_RST_n = 1'b1;
        model_reset();

        // 1: stream from a random phase; lock right after the 3rd vsync fall
        run_vsyncs(2);
        check("t1_unlocked_after_2", 32'(bus.locked), 0);
        run_vsyncs(1);
        check("t1_locked_after_3", 32'(bus.locked), 1);
        check("t1_err", 32'(bus.err_cnt), 0);
        cyc = 0;
        do begin
            gen_tick(1'b0);
            cyc++;
        end while (bus.frame_start !== 1'b1 && cyc < 2 * FRAME);
        check("t1_fs_period", cyc, FRAME);

        // 2: one frame of ready cycles and position tracking
        rdy = 0; fh = -1; fv = -1; lag_bad = 0;
        repeat (FRAME) begin
            gen_tick(1'b0);
            if (bus.vga_Ready === 1'b1) begin
                if (rdy == 0) begin
                    fh = int'(bus.pos_H);
                    fv = int'(bus.pos_V);
                end
                rdy++;
            end
            if (int'(bus.pos_H) != drove_h || int'(bus.pos_V) != drove_v) lag_bad++;
        end
        check("t2_ready_count", rdy, ACT_PIX);
        check("t2_first_h", fh, H_SYNC + H_BACK);
        check("t2_first_v", fv, V_SYNC + V_BACK);
        check("t2_pos_track", lag_bad, 0);

        // 3: one line stretched by a clock
        goto_gen(H_TOTAL / 2, V_TOTAL / 2);
        gen_tick(1'b1);
        cyc = 0;
        do begin
            gen_tick(1'b0);
            cyc++;
        end while (!last_hsf && cyc < 2 * H_TOTAL);
        check("t3_unlock", 32'(bus.locked), 0);
        check("t3_err", 32'(bus.err_cnt), 1);
        run_vsyncs(2);
        check("t3_still_unlocked", 32'(bus.locked), 0);
        run_vsyncs(1);
        check("t3_relock", 32'(bus.locked), 1);

        // 4: HS stalled high
        unlock_ph = -1;
        repeat (1100) begin
            tick(1'b1, gv >= V_SYNC);
            if (unlock_ph < 0 && bus.locked === 1'b0) unlock_ph = int'(bus.pos_H);
        end
        check("t4_unlock_at", unlock_ph, 1023);
        check("t4_err", 32'(bus.err_cnt), 2);
        check("t4_pos_H_hold", 32'(bus.pos_H), 1023);
        check("t4_ready", 32'(bus.vga_Ready), 0);
        run_vsyncs(3);
        check("t4_relock", 32'(bus.locked), 1);

        // 5: reset pulse mid-frame
        goto_gen($urandom_range(H_SYNC, H_TOTAL - 1), V_TOTAL / 2);
        vga_RST_n = 1'b0;
        #1;
        check("t5_pos_H", 32'(bus.pos_H), 0);
        check("t5_pos_V", 32'(bus.pos_V), 0);
        check("t5_locked", 32'(bus.locked), 0);
        check("t5_err", 32'(bus.err_cnt), 0);
        @(posedge vga_CLK);
        #1 vga_RST_n = 1'b1;
        model_reset();
        run_vsyncs(2);
        check("t5_unlocked_after_2", 32'(bus.locked), 0);
        run_vsyncs(1);
        check("t5_relock", 32'(bus.locked), 1);

        // 6: one HS pulse a clock short
        goto_gen(0, V_TOTAL / 2);
        hs_w = H_SYNC - 1;
        repeat (H_TOTAL) gen_tick(1'b0);
        hs_w = H_SYNC;
        repeat (H_TOTAL) gen_tick(1'b0);
`ifdef VGA_PULSE_CHECK_EN
        check("t6_locked", 32'(bus.locked), 0);
        check("t6_err", 32'(bus.err_cnt), 1);
`else
        check("t6_locked", 32'(bus.locked), 1);
        check("t6_err", 32'(bus.err_cnt), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
